// File: rtl/key_led_pkg.sv
// Shared definitions for the key-driven LED mode controller: mode encodings,
// key bit positions and the per-mode pattern reload value.
package key_led_pkg;

    typedef enum logic [1:0] {
        MODE_ALL   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_SHL   = 2'd2,
        MODE_SHR   = 2'd3
    } mode_t;

    localparam int KEY_NEXT = 0;
    localparam int KEY_PREV = 1;
    localparam int KEY_RUN  = 2;
    localparam int KEY_RST  = 3;

    // Widest LED bank the reload helper can describe; callers truncate to their width.
    localparam int LED_W_MAX = 64;

    function automatic logic [LED_W_MAX-1:0] reload_value(input mode_t m, input int unsigned led_w);
        logic [LED_W_MAX-1:0] one;
        one = LED_W_MAX'(1);
        case (m)
            MODE_SHL: return one;
            MODE_SHR: return one << (led_w - 1);
            // led_w == LED_W_MAX shifts out to zero, and zero minus one is still all ones
            default:  return (one << led_w) - one;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: pulses tick once every TICK_DIV enabled cycles. clr restarts the
// interval; a disabled counter holds its value so a pause loses nothing.
module tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && !clr && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/key_led_mode.sv
// LED mode controller: key pulses select mode, pause/resume and restart; the
// pattern register steps once per prescaler tick while running.
module key_led_mode
    import key_led_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000,
    parameter int LED_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       press,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             running
);

    mode_t            mode_q, mode_d;
    logic             run_q, run_d;
    logic [LED_W-1:0] pat_q, pat_d, advanced;
    logic             reload;
    logic             tick;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (run_q),
        .clr   (reload),
        .tick  (tick)
    );

    always_comb begin
        advanced = pat_q;
        case (mode_q)
            MODE_BLINK: advanced = ~pat_q;
            MODE_SHL:   advanced = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
            MODE_SHR:   advanced = {pat_q[0], pat_q[LED_W-1:1]};
            default:    advanced = pat_q;
        endcase
    end

    // Restart outranks everything; a mode step and a run toggle may coexist.
    always_comb begin
        mode_d = mode_q;
        run_d  = run_q;
        reload = 1'b0;
        pat_d  = pat_q;
        if (press[KEY_RST]) begin
            reload = 1'b1;
            run_d  = 1'b1;
        end else begin
            if (press[KEY_NEXT] && !press[KEY_PREV]) begin
                mode_d = mode_t'(mode_q + 2'd1);
                reload = 1'b1;
            end else if (press[KEY_PREV] && !press[KEY_NEXT]) begin
                mode_d = mode_t'(mode_q - 2'd1);
                reload = 1'b1;
            end
            if (press[KEY_RUN]) begin
                run_d = !run_q;
            end
        end
        if (reload) begin
            pat_d = LED_W'(reload_value(mode_d, LED_W));
        end else if (tick) begin
            pat_d = advanced;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_ALL;
            run_q  <= 1'b1;
            pat_q  <= '1;
        end else begin
            mode_q <= mode_d;
            run_q  <= run_d;
            pat_q  <= pat_d;
        end
    end

    assign led     = pat_q;
    assign mode    = mode_q;
    assign running = run_q;

endmodule

// File: tb/tb_key_led_mode.sv
// Self-checking bench for key_led_mode: directed walk through the key
// behaviours plus random key traffic, all compared against a behavioural model.
module tb_key_led_mode;

    localparam int TD = 4;
    localparam int LW = 4;
    localparam int ALL_ONES = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    press = 4'd0;
    logic [LW-1:0] led;
    logic [1:0]    mode;
    logic          running;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int m_mode = 0;
    int m_run  = 1;
    int m_pat  = ALL_ONES;
    int m_cnt  = 0;

    key_led_mode #(.TICK_DIV(TD), .LED_W(LW)) dut (
        .clk     (clk),
        .reset   (reset),
        .press   (press),
        .led     (led),
        .mode    (mode),
        .running (running)
    );

    always #5 clk = ~clk;

    function automatic int reload_of(input int md);
        if (md == 2) return 1;
        if (md == 3) return 1 << (LW - 1);
        return ALL_ONES;
    endfunction

    function automatic int step_of(input int md, input int p);
        case (md)
            1:       return (~p) & ALL_ONES;
            2:       return ((p << 1) | (p >> (LW - 1))) & ALL_ONES;
            3:       return ((p >> 1) | (p << (LW - 1))) & ALL_ONES;
            default: return p;
        endcase
    endfunction

    task automatic model_edge(input logic [3:0] p, input logic r);
        int  run_before;
        bit  reloaded;
        run_before = m_run;
        reloaded   = 1'b0;
        if (r) begin
            m_mode = 0; m_run = 1; m_cnt = 0; m_pat = ALL_ONES;
            return;
        end
        if (p[3]) begin
            m_pat = reload_of(m_mode); m_cnt = 0; m_run = 1;
            return;
        end
        if (p[0] != p[1]) begin
            m_mode   = p[0] ? (m_mode + 1) % 4 : (m_mode + 3) % 4;
            m_pat    = reload_of(m_mode);
            m_cnt    = 0;
            reloaded = 1'b1;
        end
        if (p[2]) m_run = 1 - run_before;
        if (run_before == 1 && !reloaded) begin
            if (m_cnt == TD - 1) begin
                m_cnt = 0;
                m_pat = step_of(m_mode, m_pat);
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_led", int'(led), m_pat);
        chk("model_mode", int'(mode), m_mode);
        chk("model_running", int'(running), m_run);
    endtask

    // drive inputs, clock one edge, advance model, then compare away from the edge
    task automatic cycle(input logic [3:0] p, input logic r);
        press = p;
        reset = r;
        @(posedge clk);
        model_edge(p, r);
        @(negedge clk);
        press = 4'd0;
        reset = 1'b0;
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'd0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        cycle(4'd0, 1'b1);
        idle(12);
        chk("reset_led", int'(led), 15);
        chk("reset_mode", int'(mode), 0);
        chk("reset_running", int'(running), 1);

        // next twice -> SHL, then rotate every TD cycles
        cycle(4'b0001, 1'b0);
        chk("next_to_blink", int'(mode), 1);
        idle(1);
        cycle(4'b0001, 1'b0);
        chk("next_to_shl", int'(mode), 2);
        chk("shl_reload", int'(led), 4'b0001);
        idle(3);
        chk("shl_hold", int'(led), 4'b0001);
        idle(1);
        chk("shl_step1", int'(led), 4'b0010);
        idle(4);
        chk("shl_step2", int'(led), 4'b0100);
        idle(4);
        chk("shl_step3", int'(led), 4'b1000);
        idle(4);
        chk("shl_wrap", int'(led), 4'b0001);

        // prev from ALL wraps to SHR
        cycle(4'd0, 1'b1);
        cycle(4'b0010, 1'b0);
        chk("prev_to_shr", int'(mode), 3);
        chk("shr_reload", int'(led), 4'b1000);
        idle(4);
        chk("shr_step1", int'(led), 4'b0100);
        idle(12);
        chk("shr_full_turn", int'(led), 4'b1000);

        // BLINK pause/resume keeps the partial interval
        cycle(4'd0, 1'b1);
        cycle(4'b0001, 1'b0);
        idle(4);
        chk("blink_toggle", int'(led), 4'b0000);
        idle(1);
        cycle(4'b0100, 1'b0);
        chk("pause_running", int'(running), 0);
        idle(20);
        chk("paused_led", int'(led), 4'b0000);
        chk("paused_running", int'(running), 0);
        cycle(4'b0100, 1'b0);
        chk("resume_running", int'(running), 1);
        idle(1);
        chk("resume_not_yet", int'(led), 4'b0000);
        idle(1);
        chk("resume_toggle", int'(led), 4'b1111);

        // next+prev together is a no-op on mode
        cycle(4'b0011, 1'b0);
        chk("both_steps_mode", int'(mode), 1);

        // restart with next while paused in SHL
        cycle(4'd0, 1'b1);
        cycle(4'b0001, 1'b0);
        cycle(4'b0001, 1'b0);
        idle(2);
        cycle(4'b0100, 1'b0);
        idle(3);
        cycle(4'b1001, 1'b0);
        chk("restart_mode", int'(mode), 2);
        chk("restart_led", int'(led), 4'b0001);
        chk("restart_running", int'(running), 1);

        // reset mid-animation in SHR
        cycle(4'd0, 1'b1);
        cycle(4'b0010, 1'b0);
        idle(8);
        chk("shr_before_reset", int'(led), 4'b0010);
        cycle(4'b0001, 1'b1);
        chk("midreset_led", int'(led), 15);
        chk("midreset_mode", int'(mode), 0);
        chk("midreset_running", int'(running), 1);

        // random key traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] p;
            logic       r;
            for (int b = 0; b < 4; b++) p[b] = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 299) == 0);
            cycle(p, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_led_mode.md
# key_led_mode

Mode controller directly downstream of the 4-key debounce driver. Consumes its one-cycle `press[3:0]` pulses and drives an LED bank through four display modes (all-on, blink, rotate-left, rotate-right). Keys select the next or previous mode, pause or resume animation, and restart the pattern. The animation rate comes from an internal prescaler.

## Interface
- `TICK_DIV`, default 12_500_000: clock cycles per animation step (0.25 s at 50 MHz); legal range ≥ 2.
- `LED_W`, default 4: LED bank width; legal range ≥ 2.
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `press`  in  4: one-cycle pulses from the key driver. Bit 0 selects the next mode, bit 1 the previous mode, bit 2 toggles run/pause, bit 3 restarts.
- `led`  out  LED_W: registered LED drive, 1 = on.
- `mode`  out  2: current mode. 0 ALL, 1 BLINK, 2 SHL, 3 SHR.
- `running`  out  1: 1 = animation advancing, 0 = paused.

## Operation
- State: `mode` (2 b), `running` (1 b), `pattern` (LED_W b), prescaler count (`$clog2(TICK_DIV)` b).
- Reload values per mode:
  - ALL: all ones.
  - BLINK: all ones.
  - SHL: `1` in LSB only (0…01).
  - SHR: `1` in MSB only (10…0).
- On each tick, per mode:
  - ALL: pattern held.
  - BLINK: pattern inverted.
  - SHL: rotate left by 1, MSB wraps to LSB.
  - SHR: rotate right by 1, LSB wraps to MSB.
- Per-cycle event resolution, highest priority first:
  1. `reset`: mode=ALL, running=1, count=0, pattern=all ones.
  2. `press[3]`: pattern reloads for the current mode, count=0, running=1. Mode is unchanged. Any simultaneous `press[0..2]` is ignored.
  3. Mode step. `press[0]` alone: mode+1 mod 4 (SHR→ALL). `press[1]` alone: mode−1 mod 4 (ALL→SHR). Both together: no mode change. A mode change reloads the pattern for the new mode and clears count. `running` is untouched by a mode step.
  4. `press[2]`: running toggles. It may combine with a mode step in the same cycle; both take effect.
  5. Tick: only if running=1 and no reload occurred this cycle. Count wraps TICK_DIV−1→0 and the pattern advances.
- Paused: count holds its value and the pattern is frozen. Resume continues from the held count, so no partial interval is lost.
- `led` = pattern register; no extra output stage.
- `press` bits are assumed one-cycle wide. A pulse held for k cycles is treated as k events; no internal edge detection.

## Timing
- Press → `mode`/`running`/`led` update: 1 cycle. A pulse sampled at edge n is visible after edge n.
- Tick period is exactly TICK_DIV cycles while running. The first step after a reload, restart or reset lands TICK_DIV cycles after the reload edge.
- Pattern advance and count wrap occur on the same edge.
- A reload in the same cycle as a would-be tick suppresses that tick; the reload value is loaded and count=0.
- Reset mid-animation: next edge forces the reset values regardless of `press`.
- Outputs after reset: `led`=all ones, `mode`=0, `running`=1.

## Structure
- Package `key_led_pkg` holds:
  - mode encodings MODE_ALL / MODE_BLINK / MODE_SHL / MODE_SHR;
  - key bit indices KEY_NEXT=0, KEY_PREV=1, KEY_RUN=2, KEY_RST=3;
  - a reload-value function taking mode and LED_W.
- Sub-module `tick_gen` (params TICK_DIV; ports clk, reset, en, clr, tick). It is the prescaler and is reusable by other blocks.
- Top holds the mode/run registers, priority logic and pattern register.

## Test plan (TICK_DIV=4, LED_W=4)
- Reset, then 12 idle cycles → led=1111, mode=0, running=1; led constant.
- Two `press[0]` pulses 1 cycle apart → mode=1 then 2, led=0001. Then 0001→0010→0100→1000→0001 every 4 cycles.
- From ALL, one `press[1]` → mode=3, led=1000. After 4 cycles led=0100; after 16 cycles led=1000.
- In BLINK: `press[2]` 2 cycles after a toggle → led frozen and running=0 for 20 cycles. Second `press[2]` → next toggle exactly 2 cycles later.
- `press[0]` and `press[1]` in the same cycle → mode unchanged, pattern and count unaffected. `press[3]` with `press[0]` while paused in SHL → mode unchanged, led=0001, running=1.
- Assert `reset` while in SHR, running, led=0010 → next cycle led=1111, mode=0, running=1.
